matrix_stream_receiver: RTL
===========================

Name: matrix_stream_receiver

Overview:
- Consumer end of the byte-stream matrix source: issues single-cycle data_request pulses and captures the returning din/din_valid bursts.
- Assembles two signed MAT_DIM x MAT_DIM operand matrices (A, then B) in row-major order.
- Presents the pair to the matrix multiplier with a valid/ack handshake, then requests the next pair.
- Flags protocol errors: stray data, stalled bursts.

Parameters:
- N_BITS, 8, width of one signed matrix element.
- MAT_DIM, 4, matrix dimension; each matrix holds MAT_DIM*MAT_DIM elements (16 by default = one burst).
- TIMEOUT, 64, maximum idle cycles between accepted elements inside a burst before abort.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; while high the block keeps fetching matrix pairs.
- din  in  N_BITS  signed element from the stream source.
- din_valid  in  1  din is valid this cycle.
- data_request  out  1  one-cycle pulse requesting one MAT_DIM*MAT_DIM burst.
- mat_a  out  MAT_DIM*MAT_DIM*N_BITS  matrix A; element k=row*MAT_DIM+col at bits [k*N_BITS +: N_BITS].
- mat_b  out  MAT_DIM*MAT_DIM*N_BITS  matrix B, same packing as mat_a.
- pair_valid  out  1  mat_a/mat_b hold a complete pair.
- pair_ack  in  1  consumer has taken the pair.
- err_stray  out  1  sticky: din_valid seen outside a receive state.
- err_timeout  out  1  sticky: a burst stalled for more than TIMEOUT cycles.

Behaviour:
- Reset (asynchronous):
  - Outputs: data_request=0, pair_valid=0, err_stray=0, err_timeout=0, mat_a=0, mat_b=0.
  - Internal: state=IDLE, elem_cnt=0, idle_cnt=0.
- All outputs are registered.
- States: IDLE, REQ_A, RECV_A, REQ_B, RECV_B, READY.
- IDLE -> REQ_A when enable=1.
- REQ_A / REQ_B:
  - data_request=1 for exactly this one cycle.
  - elem_cnt and idle_cnt cleared.
  - Unconditional move to RECV_A / RECV_B next cycle.
- RECV_x, each cycle with din_valid=1:
  - Write din to element elem_cnt of the target matrix; elem_cnt++; idle_cnt cleared.
  - When the accepted element is number MAT_DIM*MAT_DIM-1: RECV_A -> REQ_B, RECV_B -> READY.
  - Elements beyond the count cannot occur inside RECV, because the state has already left.
- RECV_x, each cycle with din_valid=0:
  - idle_cnt++.
  - When idle_cnt reaches TIMEOUT: set err_timeout, go to IDLE. Partial matrix contents are retained but never flagged valid.
- The first element may arrive any number of cycles (<TIMEOUT) after the request. The source's turnaround is at least 2 cycles.
- READY:
  - pair_valid=1; mat_a/mat_b stable.
  - On pair_ack=1: pair_valid drops next cycle; go to REQ_A if enable=1, else IDLE.
  - pair_ack outside READY is ignored.
- enable deasserted mid-fetch: the current pair completes to READY (no abort); no new request is issued afterwards.
- din_valid in IDLE, REQ_x or READY:
  - Data is dropped; err_stray is set.
  - This covers a valid in the same cycle as data_request.
  - In READY, mat_a/mat_b must not change.
- Errors clear only on reset.
- Reset mid-burst: immediate return to IDLE; contents zeroed; no request until enable is seen after reset release.
- Elements are stored bit-exact; the block performs no arithmetic on the data. Signedness is interpreted by the consumer.
- elem_cnt is clog2(MAT_DIM*MAT_DIM)+1 bits wide; idle_cnt is clog2(TIMEOUT)+1 bits wide; neither wraps.

Test Plan:
- Nominal pair:
  - Stimulus: enable=1; source returns 16 bytes 0x00..0x0F, then 16 bytes 0xF0..0xFF, each 2 cycles after its request, back-to-back.
  - Response: exactly 2 data_request pulses; pair_valid=1; mat_a[7:0]=0x00, mat_a[127:120]=0x0F; mat_b[7:0]=0xF0 (-16); no error flags.
- Gapped stream: valid every 3rd cycle for both bursts -> same matrices as the nominal case; err_timeout=0.
- Ack handshake:
  - Hold pair_ack=0 for 20 cycles in READY, with a stray din_valid in cycle 5 -> pair_valid stays 1, matrices unchanged, err_stray=1.
  - Then pulse pair_ack with enable=1 -> new data_request within 2 cycles.
- Timeout: source stops after 7 elements of A, TIMEOUT=64 -> err_timeout=1 exactly 64 idle cycles after the 7th element; state IDLE; pair_valid never asserts.
- Disable mid-fetch: drop enable during RECV_A -> B is still requested and the pair completes; after pair_ack the block goes to IDLE with no further data_request.
- Async reset during RECV_B, after element 9 -> all outputs 0 immediately. After release with enable=1: the first data_request is a new REQ_A, and the next pair matches freshly sent data.

Source files
------------

// File: rtl/matrix_stream_receiver.sv
// Stream consumer: requests two MAT_DIM x MAT_DIM bursts, assembles matrices A and B,
// and hands the pair to the multiplier over a valid/ack handshake with sticky error flags.
module matrix_stream_receiver #(
    parameter int N_BITS  = 8,
    parameter int MAT_DIM = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 enable,
    input  logic [N_BITS-1:0]                    din,
    input  logic                                 din_valid,
    output logic                                 data_request,
    output logic [MAT_DIM*MAT_DIM*N_BITS-1:0]    mat_a,
    output logic [MAT_DIM*MAT_DIM*N_BITS-1:0]    mat_b,
    output logic                                 pair_valid,
    input  logic                                 pair_ack,
    output logic                                 err_stray,
    output logic                                 err_timeout
);

    localparam int ELEMS  = MAT_DIM * MAT_DIM;
    localparam int CNT_W  = $clog2(ELEMS) + 1;
    localparam int IDLE_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ_A  = 3'd1,
        ST_RECV_A = 3'd2,
        ST_REQ_B  = 3'd3,
        ST_RECV_B = 3'd4,
        ST_READY  = 3'd5
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CNT_W-1:0]    elem_cnt_r;
    logic [CNT_W-1:0]    elem_cnt_nxt_s;
    logic [IDLE_W-1:0]   idle_cnt_r;
    logic [IDLE_W-1:0]   idle_cnt_nxt_s;
    logic                in_recv_s;
    logic                last_elem_s;
    logic                timeout_s;
    logic                data_request_nxt_s;
    logic                pair_valid_nxt_s;
    logic                err_stray_nxt_s;
    logic                err_timeout_nxt_s;

    assign in_recv_s   = (state_r == ST_RECV_A) || (state_r == ST_RECV_B);
    assign last_elem_s = (elem_cnt_r == CNT_W'(ELEMS - 1));
    // One more empty cycle on top of TIMEOUT-1 already counted trips the abort.
    assign timeout_s   = (idle_cnt_r == IDLE_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) state_nxt_s = ST_REQ_A;
                else        state_nxt_s = ST_IDLE;
            end
            ST_REQ_A: state_nxt_s = ST_RECV_A;
            ST_RECV_A: begin
                if (din_valid) state_nxt_s = last_elem_s ? ST_REQ_B : ST_RECV_A;
                else if (timeout_s) state_nxt_s = ST_IDLE;
                else state_nxt_s = ST_RECV_A;
            end
            ST_REQ_B: state_nxt_s = ST_RECV_B;
            ST_RECV_B: begin
                if (din_valid) state_nxt_s = last_elem_s ? ST_READY : ST_RECV_B;
                else if (timeout_s) state_nxt_s = ST_IDLE;
                else state_nxt_s = ST_RECV_B;
            end
            ST_READY: begin
                if (pair_ack) state_nxt_s = enable ? ST_REQ_A : ST_IDLE;
                else          state_nxt_s = ST_READY;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output and counter next values; outputs are registered below so they follow the state.
    always_comb begin
        elem_cnt_nxt_s = elem_cnt_r;
        idle_cnt_nxt_s = idle_cnt_r;
        case (state_r)
            ST_REQ_A, ST_REQ_B: begin
                elem_cnt_nxt_s = '0;
                idle_cnt_nxt_s = '0;
            end
            ST_RECV_A, ST_RECV_B: begin
                if (din_valid) begin
                    elem_cnt_nxt_s = elem_cnt_r + CNT_W'(1);
                    idle_cnt_nxt_s = '0;
                end else begin
                    idle_cnt_nxt_s = idle_cnt_r + IDLE_W'(1);
                end
            end
            default: begin
                elem_cnt_nxt_s = elem_cnt_r;
                idle_cnt_nxt_s = idle_cnt_r;
            end
        endcase
        data_request_nxt_s = (state_nxt_s == ST_REQ_A) || (state_nxt_s == ST_REQ_B);
        pair_valid_nxt_s   = (state_nxt_s == ST_READY);
        err_stray_nxt_s    = err_stray | (din_valid & ~in_recv_s);
        err_timeout_nxt_s  = err_timeout | (in_recv_s & ~din_valid & timeout_s);
    end

    // Registered outputs, counters and matrix storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_cnt_r   <= '0;
            idle_cnt_r   <= '0;
            data_request <= 1'b0;
            pair_valid   <= 1'b0;
            err_stray    <= 1'b0;
            err_timeout  <= 1'b0;
            mat_a        <= '0;
            mat_b        <= '0;
        end else begin
            elem_cnt_r   <= elem_cnt_nxt_s;
            idle_cnt_r   <= idle_cnt_nxt_s;
            data_request <= data_request_nxt_s;
            pair_valid   <= pair_valid_nxt_s;
            err_stray    <= err_stray_nxt_s;
            err_timeout  <= err_timeout_nxt_s;
            for (int k = 0; k < ELEMS; k++) begin
                if (din_valid && (elem_cnt_r == CNT_W'(k))) begin
                    if (state_r == ST_RECV_A) mat_a[k*N_BITS +: N_BITS] <= din;
                    else if (state_r == ST_RECV_B) mat_b[k*N_BITS +: N_BITS] <= din;
                    else mat_a[k*N_BITS +: N_BITS] <= mat_a[k*N_BITS +: N_BITS];
                end
            end
        end
    end

endmodule
